// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the TX frame path and the RX side.
//   uart_state_t : frame FSM states (BREAK only reachable with UART_TX_BREAK_EN)
//   par_mode_t   : parity selection; the raw 2'b11 encoding is folded to PAR_NONE
//   cnt_w()      : register width needed to count 0..n-1 (never less than 1)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, pulsing wrap for one
// clock on the last count of each bit period.
//   clk, reset : clock, synchronous active-high reset
//   clr        : hold the counter at 0 (next period starts fresh when released)
//   wrap       : last clock of the current bit period
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic wrap
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1 LAST is 0, so wrap fires every enabled clock.
  assign wrap = !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (wrap)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one DATA_W-bit word per valid/ready handshake, sent as
// start + data (LSB first) + optional parity + 1 or 2 stop bits, each bit
// CLKS_PER_BIT clocks long. Frame options are latched with the word.
//   clk, reset : clock, synchronous active-high reset
//   tx_valid/tx_ready : word handshake; tx_data, par_mode, stop2, tx_err ride with it
//   brk        : (UART_TX_BREAK_EN only) hold line low while high, then 2-bit mark
//   tx         : serial line, idle high, registered
//   busy       : any state other than IDLE
// Optional feature macro: UART_TX_BREAK_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              tx_err,
`ifdef UART_TX_BREAK_EN
  input  logic              brk,
`endif
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_t       state, state_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] data_q;
  par_mode_t         par_q;
  logic              stop2_q, err_q;
  logic              tx_d, wrap, accept, has_par, par_bit;

  // Counter is parked at 0 whenever no bit period is running, so the first
  // period after leaving IDLE/BREAK is a full CLKS_PER_BIT long.
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == IDLE) || (state == BREAK)),
    .wrap  (wrap)
  );

`ifdef UART_TX_BREAK_EN
  assign tx_ready = (state == IDLE) && !brk;
`else
  assign tx_ready = (state == IDLE);
`endif
  assign accept  = tx_valid && tx_ready;
  assign busy    = (state != IDLE);
  assign has_par = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  // Parity of the data word equals the XOR of every bit shifted out.
  assign par_bit = ((par_q == PAR_ODD) ? ~^data_q : ^data_q) ^ err_q;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) state_d = BREAK;
        else
`endif
        if (tx_valid) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: if (wrap) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (wrap) begin
        if (bit_cnt == LAST_BIT) begin
          state_d   = has_par ? PARITY : STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      PARITY: if (wrap) begin
        state_d   = STOP;
        bit_cnt_d = '0;
      end
      // bit_cnt counts stop bits here: 0 only, or 0 then 1 when stop2.
      STOP: if (wrap) begin
        if (stop2_q && (bit_cnt == '0)) begin
          bit_cnt_d = BW'(1);
        end else begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
`ifdef UART_TX_BREAK_EN
      // Mark-after-break reuses STOP with two stop bits forced.
      BREAK: if (!brk) begin
        state_d   = STOP;
        bit_cnt_d = '0;
      end
`endif
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Line level follows the state being entered so tx stays a clean register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = data_q[bit_cnt_d];
      PARITY: tx_d = par_bit;
      BREAK:  tx_d = 1'b0;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx      <= 1'b1;
      data_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
      if (accept) begin
        data_q  <= tx_data;
        par_q   <= (par_mode == 2'b11) ? PAR_NONE : par_mode_t'(par_mode);
        stop2_q <= stop2;
        err_q   <= tx_err;
      end
`ifdef UART_TX_BREAK_EN
      if ((state == BREAK) && !brk) stop2_q <= 1'b1;
`endif
    end
  end

endmodule
